// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard controller: FSM state encoding and sizing helpers.
// Ports: none (package).
// Imported by the controller top and the performance counter.
package hazard_ctrl_pkg;

    // Memory-freeze FSM: RUN = pipeline free, WAIT = multi-cycle data access in flight.
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    localparam int DEF_LEN_REG_FILE_ADDR = 5;
    localparam int DEF_MEM_LATENCY       = 1;
    localparam int DEF_LEN_COUNT         = 16;

    // Width of the WAIT down-counter; it must hold MEM_LATENCY-1 and never be zero width.
    function automatic int cnt_width(input int mem_latency);
        int w;
        w = $clog2(mem_latency + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard bundle between the pipeline datapath and the hazard controller.
// master: datapath side (drives hazard sources, receives hold/flush controls and counters).
// slave : controller side (the reverse).
interface hazard_ctrl_if #(
    parameter int LEN_REG_FILE_ADDR = 5,
    parameter int LEN_COUNT         = 16
);
    logic [LEN_REG_FILE_ADDR-1:0] id_reg_1;
    logic [LEN_REG_FILE_ADDR-1:0] id_reg_2;
    logic                         id_uses_reg_2;
    logic                         ex_mem_read;
    logic [LEN_REG_FILE_ADDR-1:0] ex_dst_reg;
    logic                         branch_taken;
    logic                         mem_start;

    logic                         pc_write;
    logic                         if2id_write;
    logic                         if2id_flush;
    logic                         id2ex_flush;
    logic                         pipe_stall;
    logic [LEN_COUNT-1:0]         bubble_count;
    logic [LEN_COUNT-1:0]         stall_count;

    modport master (
        output id_reg_1, id_reg_2, id_uses_reg_2, ex_mem_read, ex_dst_reg, branch_taken, mem_start,
        input  pc_write, if2id_write, if2id_flush, id2ex_flush, pipe_stall, bubble_count, stall_count
    );

    modport slave (
        input  id_reg_1, id_reg_2, id_uses_reg_2, ex_mem_read, ex_dst_reg, branch_taken, mem_start,
        output pc_write, if2id_write, if2id_flush, id2ex_flush, pipe_stall, bubble_count, stall_count
    );
endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the bubble and stall performance counters.
// Ports: clk, reset (async active-low), inc (count this cycle), count (current value).
// Latency: count reflects inc one edge later; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int LEN_COUNT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inc,
    output logic [LEN_COUNT-1:0] count
);
    logic [LEN_COUNT-1:0] count_q;
    logic [LEN_COUNT-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubble, taken-branch flush, multi-cycle memory freeze, perf counters.
// Ports: clk, reset (async active-low), hz (slave side of hazard_ctrl_if).
// Latency: controls are combinational from state+inputs; FSM and counters update on posedge clk.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int LEN_REG_FILE_ADDR = DEF_LEN_REG_FILE_ADDR,
    parameter int MEM_LATENCY       = DEF_MEM_LATENCY,
    parameter int LEN_COUNT         = DEF_LEN_COUNT
) (
    input  logic          clk,
    input  logic          reset,
    hazard_ctrl_if.slave  hz
);
    localparam int CNT_W = cnt_width(MEM_LATENCY);
    localparam bit MULTI = (MEM_LATENCY > 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [LEN_REG_FILE_ADDR-1:0] ex_dst, id_r1, id_r2;
    logic                         load_use;
    logic                         stall_start;
    logic                         stall;

    logic                         pc_write, if2id_write, if2id_flush, id2ex_flush, pipe_stall;
    logic [LEN_COUNT-1:0]         bubble_cnt, stall_cnt;

    assign ex_dst = hz.ex_dst_reg;
    assign id_r1  = hz.id_reg_1;
    assign id_r2  = hz.id_reg_2;

    // Register 0 is hard-wired zero, so a load targeting it never creates a dependency.
    assign load_use = hz.ex_mem_read && (ex_dst != '0) &&
                      ((ex_dst == id_r1) || (hz.id_uses_reg_2 && (ex_dst == id_r2)));

    // The first freeze cycle is the RUN cycle that sees mem_start; the WAIT cycle with cnt==1
    // lets the pipeline advance, giving MEM_LATENCY-1 frozen cycles in total.
    assign stall_start = (state_q == ST_RUN) && hz.mem_start && MULTI;
    assign stall       = stall_start || ((state_q == ST_WAIT) && (cnt_q > CNT_W'(1)));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (stall_start) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(MEM_LATENCY - 1);
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Freeze dominates so hazards are re-evaluated once the pipeline moves again;
    // a taken branch squashes the dependent instruction anyway, so it beats load-use.
    always_comb begin
        pc_write    = 1'b1;
        if2id_write = 1'b1;
        if2id_flush = 1'b0;
        id2ex_flush = 1'b0;
        pipe_stall  = 1'b0;
        if (!reset) begin
            pc_write    = 1'b0;
            if2id_write = 1'b0;
            if2id_flush = 1'b1;
            id2ex_flush = 1'b1;
        end else if (stall) begin
            pc_write    = 1'b0;
            if2id_write = 1'b0;
            pipe_stall  = 1'b1;
        end else if (hz.branch_taken) begin
            if2id_flush = 1'b1;
            id2ex_flush = 1'b1;
        end else if (load_use) begin
            pc_write    = 1'b0;
            if2id_write = 1'b0;
            id2ex_flush = 1'b1;
        end
    end

    // id2ex_flush is forced high during reset; those cycles are not bubbles.
    sat_counter #(.LEN_COUNT(LEN_COUNT)) u_bubble_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (id2ex_flush && reset),
        .count (bubble_cnt)
    );

    sat_counter #(.LEN_COUNT(LEN_COUNT)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (pipe_stall),
        .count (stall_cnt)
    );

    assign hz.pc_write     = pc_write;
    assign hz.if2id_write  = if2id_write;
    assign hz.if2id_flush  = if2id_flush;
    assign hz.id2ex_flush  = id2ex_flush;
    assign hz.pipe_stall   = pipe_stall;
    assign hz.bubble_count = bubble_cnt;
    assign hz.stall_count  = stall_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: three instances (latency 1, 3, and 4 with 3-bit counters).
// Inputs change 1 time unit after posedge; outputs are checked 1 unit later, far from any edge.
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic ra, rb, rc;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.LEN_REG_FILE_ADDR(5), .LEN_COUNT(16)) ia ();
    hazard_ctrl_if #(.LEN_REG_FILE_ADDR(5), .LEN_COUNT(16)) ib ();
    hazard_ctrl_if #(.LEN_REG_FILE_ADDR(5), .LEN_COUNT(3))  ic ();

    hazard_ctrl #(.LEN_REG_FILE_ADDR(5), .MEM_LATENCY(1), .LEN_COUNT(16)) dut_a (.clk(clk), .reset(ra), .hz(ia));
    hazard_ctrl #(.LEN_REG_FILE_ADDR(5), .MEM_LATENCY(3), .LEN_COUNT(16)) dut_b (.clk(clk), .reset(rb), .hz(ib));
    hazard_ctrl #(.LEN_REG_FILE_ADDR(5), .MEM_LATENCY(4), .LEN_COUNT(3))  dut_c (.clk(clk), .reset(rc), .hz(ic));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        ra = 1'b0; rb = 1'b0; rc = 1'b0;
        ia.id_reg_1 = '0; ia.id_reg_2 = '0; ia.id_uses_reg_2 = 1'b0; ia.ex_mem_read = 1'b0;
        ia.ex_dst_reg = '0; ia.branch_taken = 1'b0; ia.mem_start = 1'b0;
        ib.id_reg_1 = '0; ib.id_reg_2 = '0; ib.id_uses_reg_2 = 1'b0; ib.ex_mem_read = 1'b0;
        ib.ex_dst_reg = '0; ib.branch_taken = 1'b0; ib.mem_start = 1'b0;
        ic.id_reg_1 = '0; ic.id_reg_2 = '0; ic.id_uses_reg_2 = 1'b0; ic.ex_mem_read = 1'b0;
        ic.ex_dst_reg = '0; ic.branch_taken = 1'b0; ic.mem_start = 1'b0;

        // 1. reset held for 3 cycles, then released with no hazards
        settle();
        chk("rst_pc_write", ia.pc_write, 1'b0);
        chk("rst_if2id_write", ia.if2id_write, 1'b0);
        chk("rst_if2id_flush", ia.if2id_flush, 1'b1);
        chk("rst_id2ex_flush", ia.id2ex_flush, 1'b1);
        chk("rst_pipe_stall", ia.pipe_stall, 1'b0);
        tick(); tick();
        chk("rst_bubble_no_inc", ia.bubble_count, 16'd0);
        tick();
        ra = 1'b1; rb = 1'b1; rc = 1'b1;
        settle();
        chk("run_pc_write", ia.pc_write, 1'b1);
        chk("run_if2id_write", ia.if2id_write, 1'b1);
        chk("run_if2id_flush", ia.if2id_flush, 1'b0);
        chk("run_id2ex_flush", ia.id2ex_flush, 1'b0);
        chk("run_bubble_a", ia.bubble_count, 16'd0);
        chk("run_stall_a", ia.stall_count, 16'd0);
        chk("run_stall_b", ib.stall_count, 16'd0);
        chk("run_bubble_c", ic.bubble_count, 3'd0);

        // 2. load-use on rs: one bubble
        tick();
        ia.ex_mem_read = 1'b1; ia.ex_dst_reg = 5'd5; ia.id_reg_1 = 5'd5;
        settle();
        chk("lu_pc_write", ia.pc_write, 1'b0);
        chk("lu_if2id_write", ia.if2id_write, 1'b0);
        chk("lu_if2id_flush", ia.if2id_flush, 1'b0);
        chk("lu_id2ex_flush", ia.id2ex_flush, 1'b1);
        tick();
        ia.ex_mem_read = 1'b0;
        settle();
        chk("lu_after_pc_write", ia.pc_write, 1'b1);
        chk("lu_after_id2ex_flush", ia.id2ex_flush, 1'b0);
        chk("lu_bubble_1", ia.bubble_count, 16'd1);
        // load to r0 is never a hazard
        ia.ex_mem_read = 1'b1; ia.ex_dst_reg = 5'd0; ia.id_reg_1 = 5'd0;
        settle();
        chk("lu_r0_pc_write", ia.pc_write, 1'b1);
        chk("lu_r0_id2ex_flush", ia.id2ex_flush, 1'b0);
        tick();
        // rt match ignored when rt is not read
        ia.ex_dst_reg = 5'd5; ia.id_reg_1 = 5'd3; ia.id_reg_2 = 5'd5; ia.id_uses_reg_2 = 1'b0;
        settle();
        chk("lu_rt_unused_flush", ia.id2ex_flush, 1'b0);
        chk("lu_r0_bubble", ia.bubble_count, 16'd1);
        tick();
        ia.id_uses_reg_2 = 1'b1;
        settle();
        chk("lu_rt_used_flush", ia.id2ex_flush, 1'b1);
        chk("lu_rt_used_pc_write", ia.pc_write, 1'b0);
        tick();
        ia.ex_mem_read = 1'b0;
        settle();
        chk("lu_bubble_2", ia.bubble_count, 16'd2);

        // 3. branch beats a simultaneous load-use
        ia.ex_mem_read = 1'b1; ia.branch_taken = 1'b1;
        settle();
        chk("br_pc_write", ia.pc_write, 1'b1);
        chk("br_if2id_write", ia.if2id_write, 1'b1);
        chk("br_if2id_flush", ia.if2id_flush, 1'b1);
        chk("br_id2ex_flush", ia.id2ex_flush, 1'b1);
        tick();
        ia.ex_mem_read = 1'b0; ia.branch_taken = 1'b0;
        settle();
        chk("br_bubble_3", ia.bubble_count, 16'd3);
        chk("br_after_if2id_flush", ia.if2id_flush, 1'b0);

        // 4. latency 3, mem_start held high: 2 stall, 1 advance, 2 stall, 1 advance
        ib.mem_start = 1'b1;
        settle();
        chk("ml3_c1_stall", ib.pipe_stall, 1'b1);
        chk("ml3_c1_pc_write", ib.pc_write, 1'b0);
        chk("ml3_c1_sc", ib.stall_count, 16'd0);
        tick();
        chk("ml3_c2_stall", ib.pipe_stall, 1'b1);
        chk("ml3_c2_if2id_write", ib.if2id_write, 1'b0);
        chk("ml3_c2_sc", ib.stall_count, 16'd1);
        tick();
        chk("ml3_c3_stall", ib.pipe_stall, 1'b0);
        chk("ml3_c3_pc_write", ib.pc_write, 1'b1);
        chk("ml3_c3_sc", ib.stall_count, 16'd2);
        tick();
        chk("ml3_c4_stall", ib.pipe_stall, 1'b1);
        chk("ml3_c4_sc", ib.stall_count, 16'd2);
        tick();
        chk("ml3_c5_stall", ib.pipe_stall, 1'b1);
        chk("ml3_c5_sc", ib.stall_count, 16'd3);
        tick();
        chk("ml3_c6_stall", ib.pipe_stall, 1'b0);
        chk("ml3_c6_sc", ib.stall_count, 16'd4);
        ib.mem_start = 1'b0;
        tick();
        chk("ml3_idle_stall", ib.pipe_stall, 1'b0);
        chk("ml3_idle_sc", ib.stall_count, 16'd4);

        // 5. latency 4: reset pulsed during the 2nd stall cycle
        ic.mem_start = 1'b1;
        settle();
        chk("ml4_c1_stall", ic.pipe_stall, 1'b1);
        tick();
        ic.mem_start = 1'b0;
        settle();
        chk("ml4_c2_stall", ic.pipe_stall, 1'b1);
        chk("ml4_c2_sc", ic.stall_count, 3'd1);
        rc = 1'b0;
        settle();
        chk("ml4_rst_stall", ic.pipe_stall, 1'b0);
        chk("ml4_rst_sc", ic.stall_count, 3'd0);
        chk("ml4_rst_id2ex_flush", ic.id2ex_flush, 1'b1);
        tick();
        rc = 1'b1;
        settle();
        chk("ml4_post_stall", ic.pipe_stall, 1'b0);
        chk("ml4_post_pc_write", ic.pc_write, 1'b1);
        tick();
        chk("ml4_post2_stall", ic.pipe_stall, 1'b0);
        chk("ml4_post2_sc", ic.stall_count, 3'd0);
        chk("ml4_post2_bubble", ic.bubble_count, 3'd0);

        // 6. 3-bit bubble counter saturates at 7
        ic.ex_mem_read = 1'b1; ic.ex_dst_reg = 5'd9; ic.id_reg_1 = 5'd9;
        for (int i = 0; i < 6; i++) tick();
        chk("sat_bubble_6", ic.bubble_count, 3'd6);
        for (int i = 0; i < 4; i++) tick();
        chk("sat_bubble_7", ic.bubble_count, 3'd7);
        chk("sat_still_flush", ic.id2ex_flush, 1'b1);
        ic.ex_mem_read = 1'b0;
        tick();
        chk("sat_bubble_hold", ic.bubble_count, 3'd7);

        // branch during a freeze is deferred until the pipeline advances
        ic.mem_start = 1'b1; ic.branch_taken = 1'b1;
        settle();
        chk("brst_c1_stall", ic.pipe_stall, 1'b1);
        chk("brst_c1_if2id_flush", ic.if2id_flush, 1'b0);
        chk("brst_c1_id2ex_flush", ic.id2ex_flush, 1'b0);
        chk("brst_c1_pc_write", ic.pc_write, 1'b0);
        tick();
        ic.mem_start = 1'b0;
        settle();
        chk("brst_c2_stall", ic.pipe_stall, 1'b1);
        chk("brst_c2_id2ex_flush", ic.id2ex_flush, 1'b0);
        tick();
        chk("brst_c3_stall", ic.pipe_stall, 1'b1);
        chk("brst_c3_if2id_flush", ic.if2id_flush, 1'b0);
        tick();
        chk("brst_c4_stall", ic.pipe_stall, 1'b0);
        chk("brst_c4_if2id_flush", ic.if2id_flush, 1'b1);
        chk("brst_c4_id2ex_flush", ic.id2ex_flush, 1'b1);
        chk("brst_c4_pc_write", ic.pc_write, 1'b1);
        chk("brst_c4_sc", ic.stall_count, 3'd3);
        ic.branch_taken = 1'b0;
        tick();
        chk("brst_end_flush", ic.if2id_flush, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
